// File: rtl/control_unit_if.sv
// Instruction-fetch and datapath-control bundle between control_unit (master)
// and the memory/datapath side (slave).
interface control_unit_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] instr;
    logic        dp_enable;
    logic [4:0]  dp_a;
    logic [4:0]  dp_b;
    logic [4:0]  dp_w;
    logic [63:0] dp_din;
    logic        dp_load_store;
    logic        dp_op_ula;
    logic        dp_operation_type;
    logic        dp_ula_entry;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, instr,
        output dp_enable, dp_a, dp_b, dp_w, dp_din,
        output dp_load_store, dp_op_ula, dp_operation_type, dp_ula_entry
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, instr,
        input  dp_enable, dp_a, dp_b, dp_w, dp_din,
        input  dp_load_store, dp_op_ula, dp_operation_type, dp_ula_entry
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle RV64 subset sequencer: IDLE/FETCH/DECODE/EXEC/HALT for ld/sd/addi/add/sub.
// Optional macro CU_RETIRE_COUNT_EN adds a 32-bit retired-instruction counter output.
module control_unit (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    control_unit_if.master        bus,
    output logic                  busy,
    output logic                  halted,
    output logic                  illegal
`ifdef CU_RETIRE_COUNT_EN
    ,
    output logic [31:0]           retired
`endif
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic [2:0]  r_state;
    logic [63:0] r_pc;
    logic [31:0] r_ir;
    logic        r_illegal;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_is_ld, w_is_sd, w_is_addi, w_is_add, w_is_sub;
    logic        w_legal;

    assign w_opcode  = r_ir[6:0];
    assign w_funct3  = r_ir[14:12];
    assign w_funct7  = r_ir[31:25];
    assign w_is_ld   = (w_opcode == 7'b0000011) && (w_funct3 == 3'b011);
    assign w_is_sd   = (w_opcode == 7'b0100011) && (w_funct3 == 3'b011);
    assign w_is_addi = (w_opcode == 7'b0010011) && (w_funct3 == 3'b000);
    assign w_is_add  = (w_opcode == 7'b0110011) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0000000);
    assign w_is_sub  = (w_opcode == 7'b0110011) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0100000);
    assign w_legal   = w_is_ld | w_is_sd | w_is_addi | w_is_add | w_is_sub;

    // Datapath fields come purely from IR, so they hold steady through EXEC.
    always_comb begin
        bus.dp_a              = 5'd0;
        bus.dp_b              = 5'd0;
        bus.dp_w              = 5'd0;
        bus.dp_din            = 64'd0;
        bus.dp_load_store     = 1'b0;
        bus.dp_op_ula         = 1'b0;
        bus.dp_operation_type = 1'b0;
        bus.dp_ula_entry      = 1'b0;
        if (w_is_ld || w_is_addi) begin
            bus.dp_w              = r_ir[11:7];
            bus.dp_b              = r_ir[19:15];
            bus.dp_din            = {{52{r_ir[31]}}, r_ir[31:20]};
            bus.dp_load_store     = 1'b1;
            bus.dp_op_ula         = 1'b1;
            bus.dp_operation_type = w_is_addi;
        end else if (w_is_sd) begin
            bus.dp_a              = r_ir[24:20];
            bus.dp_b              = r_ir[19:15];
            bus.dp_din            = {{52{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            bus.dp_op_ula         = 1'b1;
        end else if (w_is_add || w_is_sub) begin
            bus.dp_w              = r_ir[11:7];
            bus.dp_b              = r_ir[19:15];
            bus.dp_a              = r_ir[24:20];
            bus.dp_load_store     = 1'b1;
            bus.dp_operation_type = 1'b1;
            bus.dp_ula_entry      = 1'b1;
            bus.dp_op_ula         = w_is_add;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= 64'd0;
            r_ir      <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        r_ir    <= bus.instr;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state   <= S_HALT;
                        r_illegal <= (r_ir != EBREAK);
                    end
                end
                S_EXEC: begin
                    r_pc    <= r_pc + 64'd4;
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CU_RETIRE_COUNT_EN
    logic [31:0] r_retired;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= 32'd0;
        end else if (r_state == S_EXEC) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`endif

    assign bus.imem_req  = (r_state == S_FETCH);
    assign bus.imem_addr = r_pc;
    assign bus.dp_enable = (r_state == S_EXEC);
    assign busy          = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted        = (r_state == S_HALT);
    assign illegal       = r_illegal;
endmodule
